// File: rtl/vec_regfile_stream_pkg.sv
// Purpose : shared configuration, FSM state type and mask helper for the vector register file.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package vrf_pkg;

  // Configuration of the register file instance.
  localparam int NUM_REGS = 8;
  localparam int VLEN     = 512;
  localparam int ELEM_W   = 32;
  localparam int BUS_W    = 32;

  // Derived constants.
  localparam int RA_W   = $clog2(NUM_REGS);
  localparam int NELEM  = VLEN / ELEM_W;
  localparam int NCHUNK = VLEN / BUS_W;
  // One spare count value so the counter can reach NCHUNK without wrapping.
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  // Expand a per-element enable into a per-bit enable across the whole vector.
  function automatic logic [VLEN-1:0] expand_mask(input logic [NELEM-1:0] mask);
    logic [VLEN-1:0] bits;
    bits = '0;
    for (int i = 0; i < NELEM; i++) begin
      bits[i*ELEM_W +: ELEM_W] = {ELEM_W{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/vec_regfile_stream_if.sv
// Purpose : bundle of read, write-back, memory command and load/store stream signals.
// Latency : n/a (wiring only).
// Backpressure: wb/cmd/ld/st each use valid/ready; slave = register file, master = its user.
interface vec_regfile_stream_if;
  import vrf_pkg::*;

  logic [RA_W-1:0]     rd0_addr;
  logic [RA_W-1:0]     rd1_addr;
  logic [VLEN-1:0]     rd0_data;
  logic [VLEN-1:0]     rd1_data;

  logic                wb_valid;
  logic                wb_ready;
  logic [RA_W-1:0]     wb_addr;
  logic [NELEM-1:0]    wb_mask;
  logic [VLEN-1:0]     wb_data;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_store;
  logic [RA_W-1:0]     cmd_reg;

  logic                ld_valid;
  logic                ld_ready;
  logic [BUS_W-1:0]    ld_data;

  logic                st_valid;
  logic                st_ready;
  logic [BUS_W-1:0]    st_data;
  logic                st_last;

  logic [NUM_REGS-1:0] reg_valid;
  logic                busy;

  modport slave (
    input  rd0_addr, rd1_addr,
    output rd0_data, rd1_data,
    input  wb_valid, wb_addr, wb_mask, wb_data,
    output wb_ready,
    input  cmd_valid, cmd_store, cmd_reg,
    output cmd_ready,
    input  ld_valid, ld_data,
    output ld_ready,
    input  st_ready,
    output st_valid, st_data, st_last,
    output reg_valid, busy
  );

  modport master (
    output rd0_addr, rd1_addr,
    input  rd0_data, rd1_data,
    output wb_valid, wb_addr, wb_mask, wb_data,
    input  wb_ready,
    output cmd_valid, cmd_store, cmd_reg,
    input  cmd_ready,
    output ld_valid, ld_data,
    input  ld_ready,
    output st_ready,
    input  st_valid, st_data, st_last,
    input  reg_valid, busy
  );

endinterface

// File: rtl/vec_regfile_stream_ctrl.sv
// Purpose : load/store stream FSM with chunk counter, load staging and store shift register.
// Latency : load commit pulses with the last accepted chunk; store chunk 0 presented the cycle after cmd.
// Backpressure: cmd_ready only in IDLE; ld_ready held in LOAD; st_data/st_last hold while st_ready low.
// Ports: cmd/ld/st handshakes; i_snap_data = register addressed by i_cmd_reg;
//        o_clr_vld / o_commit / o_commit_data / o_tgt_reg drive the storage and scoreboard.
module vrf_stream_ctrl
  import vrf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_store,
  input  logic [RA_W-1:0]  i_cmd_reg,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic [BUS_W-1:0] i_ld_data,
  output logic             o_st_valid,
  input  logic             i_st_ready,
  output logic [BUS_W-1:0] o_st_data,
  output logic             o_st_last,
  input  logic [VLEN-1:0]  i_snap_data,
  output logic             o_clr_vld,
  output logic             o_commit,
  output logic [VLEN-1:0]  o_commit_data,
  output logic [RA_W-1:0]  o_tgt_reg,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RA_W-1:0]  r_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic [VLEN-1:0]  r_stage;
  logic [VLEN-1:0]  r_shift;
  logic             w_start;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_ld_ready  = 1'b0;
    o_st_valid  = 1'b0;
    o_clr_vld   = 1'b0;
    o_commit    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_start     = 1'b1;
          o_clr_vld   = !i_cmd_store;
          w_state_nxt = i_cmd_store ? STORE : LOAD;
        end
      end
      LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid && w_cnt_last) begin
          o_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      STORE: begin
        o_st_valid = 1'b1;
        if (i_st_ready && w_cnt_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_shift <= '0;
    end else if (w_start) begin
      r_tgt <= i_cmd_reg;
      r_cnt <= '0;
      // Snapshot so write-backs during the store cannot leak into the stream.
      if (i_cmd_store) begin
        r_shift <= i_snap_data;
      end
    end else if (r_state == LOAD && i_ld_valid) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_stage[k*BUS_W +: BUS_W] <= i_ld_data;
        end
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == STORE && i_st_ready) begin
      r_shift <= r_shift >> BUS_W;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // The final chunk bypasses staging so the commit lands on the same edge it is accepted.
  always_comb begin
    o_commit_data = r_stage;
    o_commit_data[VLEN-1 -: BUS_W] = i_ld_data;
  end

  assign o_st_data = r_shift[BUS_W-1:0];
  assign o_st_last = (r_state == STORE) && w_cnt_last;
  assign o_tgt_reg = (r_state == IDLE) ? i_cmd_reg : r_tgt;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: rtl/vec_regfile_stream.sv
// Purpose : NUM_REGS x VLEN vector register file with 2 read ports, masked write-back and a load/store stream.
// Latency : reads 1 cycle (read-before-write); write-back and load commit visible to reads next cycle.
// Backpressure: wb_ready drops only when a load commit targets wb_addr; streams follow vrf_stream_ctrl.
// Ports: clk, rst_n (async, active-low); bus = vec_regfile_stream_if.slave carrying all data/handshakes.
module vec_regfile_stream
  import vrf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  vec_regfile_stream_if.slave bus
);

  logic [VLEN-1:0]     r_regs [NUM_REGS];
  logic [VLEN-1:0]     r_rd0_data;
  logic [VLEN-1:0]     r_rd1_data;
  logic [NUM_REGS-1:0] r_reg_vld;

  logic                w_clr_vld;
  logic                w_commit;
  logic [VLEN-1:0]     w_commit_data;
  logic [RA_W-1:0]     w_tgt_reg;
  logic [VLEN-1:0]     w_snap_data;
  logic [VLEN-1:0]     w_mask_bits;
  logic                w_wb_ready;
  logic                w_wb_fire;
  logic                w_cmd_ready;
  logic                w_ld_ready;
  logic                w_st_valid;
  logic [BUS_W-1:0]    w_st_data;
  logic                w_st_last;
  logic                w_busy;

  assign w_snap_data = r_regs[bus.cmd_reg];
  assign w_mask_bits = expand_mask(bus.wb_mask);
  // A load commit owns its target register for that edge; the write-back waits one cycle.
  assign w_wb_ready  = !(w_commit && (bus.wb_addr == w_tgt_reg));
  assign w_wb_fire   = bus.wb_valid && w_wb_ready;

  vrf_stream_ctrl u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (bus.cmd_valid),
    .o_cmd_ready   (w_cmd_ready),
    .i_cmd_store   (bus.cmd_store),
    .i_cmd_reg     (bus.cmd_reg),
    .i_ld_valid    (bus.ld_valid),
    .o_ld_ready    (w_ld_ready),
    .i_ld_data     (bus.ld_data),
    .o_st_valid    (w_st_valid),
    .i_st_ready    (bus.st_ready),
    .o_st_data     (w_st_data),
    .o_st_last     (w_st_last),
    .i_snap_data   (w_snap_data),
    .o_clr_vld     (w_clr_vld),
    .o_commit      (w_commit),
    .o_commit_data (w_commit_data),
    .o_tgt_reg     (w_tgt_reg),
    .o_busy        (w_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_rd0_data <= '0;
      r_rd1_data <= '0;
    end else begin
      r_rd0_data <= r_regs[bus.rd0_addr];
      r_rd1_data <= r_regs[bus.rd1_addr];
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_commit && (w_tgt_reg == RA_W'(r))) begin
          r_regs[r] <= w_commit_data;
        end else if (w_wb_fire && (bus.wb_addr == RA_W'(r))) begin
          r_regs[r] <= (r_regs[r] & ~w_mask_bits) | (bus.wb_data & w_mask_bits);
        end
      end
    end
  end

  // Clear and set never coincide: clear happens in IDLE, commit only in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_vld <= '1;
    end else if (w_clr_vld) begin
      r_reg_vld[w_tgt_reg] <= 1'b0;
    end else if (w_commit) begin
      r_reg_vld[w_tgt_reg] <= 1'b1;
    end
  end

  assign bus.rd0_data  = r_rd0_data;
  assign bus.rd1_data  = r_rd1_data;
  assign bus.wb_ready  = w_wb_ready;
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.st_valid  = w_st_valid;
  assign bus.st_data   = w_st_data;
  assign bus.st_last   = w_st_last;
  assign bus.reg_valid = r_reg_vld;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_vec_regfile_stream.sv
// Purpose : self-checking bench for vec_regfile_stream with a reference model and queue scoreboard.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge or #1 after driving.
// Backpressure: store stream exercised with st_ready toggling; load exercised with ld_valid gaps.
module tb_vec_regfile_stream;
  import vrf_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_regfile_stream_if bus();

  vec_regfile_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tot;
  int n_bad;

  logic [VLEN-1:0]     mdl [NUM_REGS];
  logic [NUM_REGS-1:0] mdl_vld;
  logic [VLEN-1:0]     rd_q [$];
  logic [BUS_W-1:0]    st_q [$];

  task automatic check_val(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int r = 0; r < NUM_REGS; r++) mdl[r] = '0;
    mdl_vld = '1;
  endtask

  task automatic mdl_wb(input logic [RA_W-1:0] a, input logic [NELEM-1:0] m, input logic [VLEN-1:0] d);
    for (int e = 0; e < NELEM; e++) begin
      if (m[e]) mdl[a][e*ELEM_W +: ELEM_W] = d[e*ELEM_W +: ELEM_W];
    end
  endtask

  task automatic read_chk(input logic [RA_W-1:0] a, input string tag);
    logic [VLEN-1:0] e;
    @(negedge clk);
    bus.rd0_addr = a;
    bus.rd1_addr = a;
    rd_q.push_back(mdl[a]);
    @(negedge clk);
    e = rd_q.pop_front();
    check_val(tag, bus.rd0_data, e);
    check_val({tag, "_p1"}, bus.rd1_data, e);
  endtask

  task automatic do_wb(input logic [RA_W-1:0] a, input logic [NELEM-1:0] m, input logic [VLEN-1:0] d);
    bit fired;
    fired = 1'b0;
    @(negedge clk);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_mask  = m;
    bus.wb_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.wb_ready) begin
        fired = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (fired) begin
      @(posedge clk);
      mdl_wb(a, m, d);
      #1;
    end else begin
      check_val("wb_timeout", 0, 1);
    end
    bus.wb_valid = 1'b0;
  endtask

  // Load base+k into chunk k. Optional ld_valid gaps, a colliding write-back on the
  // commit cycle, or an asynchronous reset just before chunk abort_at.
  task automatic do_load(input logic [RA_W-1:0] a, input logic [BUS_W-1:0] base,
                         input bit gaps, input bit collide, input int abort_at);
    logic [VLEN-1:0] exp_v;
    logic [VLEN-1:0] coll_d;
    coll_d = {(VLEN/32){32'hA5A5_5A5A}};
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_store = 1'b0;
    bus.cmd_reg   = a;
    #1;
    check_val("ld_cmd_rdy", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    mdl_vld[a] = 1'b0;
    @(negedge clk);
    check_val("ld_busy", bus.busy, 1);
    check_val("ld_cmd_rdy_lo", bus.cmd_ready, 0);
    check_val("ld_vld_clr", bus.reg_valid, mdl_vld);
    for (int k = 0; k < NCHUNK; k++) begin
      if (gaps && (k % 3 == 1)) begin
        bus.ld_valid = 1'b0;
        @(negedge clk);
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        mdl_reset();
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_cmd_rdy", bus.cmd_ready, 1);
        check_val("arst_ld_rdy", bus.ld_ready, 0);
        check_val("arst_vld", bus.reg_valid, mdl_vld);
        bus.ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("arst_cmd_rdy_rel", bus.cmd_ready, 1);
        return;
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = base + BUS_W'(k);
      if (collide && (k == NCHUNK - 1)) begin
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_mask  = '1;
        bus.wb_data  = coll_d;
        #1;
        check_val("coll_wb_rdy_lo", bus.wb_ready, 0);
      end
      if (k == NCHUNK / 2) check_val("ld_vld_mid", bus.reg_valid, mdl_vld);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    exp_v = '0;
    for (int k = 0; k < NCHUNK; k++) exp_v[k*BUS_W +: BUS_W] = base + BUS_W'(k);
    mdl[a] = exp_v;
    mdl_vld[a] = 1'b1;
    check_val("ld_vld_set", bus.reg_valid, mdl_vld);
    check_val("ld_busy_done", bus.busy, 0);
    if (collide) begin
      // Held write-back lands now; a read issued alongside still sees the load data.
      #1;
      check_val("coll_wb_rdy_hi", bus.wb_ready, 1);
      bus.rd0_addr = a;
      bus.rd1_addr = a;
      rd_q.push_back(mdl[a]);
      @(posedge clk);
      mdl_wb(a, '1, coll_d);
      #1;
      bus.wb_valid = 1'b0;
      @(negedge clk);
      check_val("coll_rd_load", bus.rd0_data, rd_q.pop_front());
    end
  endtask

  task automatic do_store(input logic [RA_W-1:0] a);
    int got;
    bit hold;
    bit wb_done;
    logic [BUS_W-1:0] prev_d;
    logic             prev_l;
    logic [BUS_W-1:0] e;
    logic [VLEN-1:0]  wb_d;
    wb_d = {(VLEN/32){32'hDEAD_BEEF}};
    got = 0; hold = 1'b0; wb_done = 1'b0; prev_d = '0; prev_l = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_store = 1'b1;
    bus.cmd_reg   = a;
    for (int k = 0; k < NCHUNK; k++) st_q.push_back(mdl[a][k*BUS_W +: BUS_W]);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && got < NCHUNK; cyc++) begin
      @(negedge clk);
      bus.wb_valid = 1'b0;
      bus.st_ready = (cyc % 2 == 0);
      #1;
      check_val("st_vld", bus.st_valid, 1);
      if (hold) begin
        check_val("st_hold_dat", bus.st_data, prev_d);
        check_val("st_hold_last", bus.st_last, prev_l);
      end
      if (got == 5 && !wb_done) begin
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_mask  = '1;
        bus.wb_data  = wb_d;
        wb_done = 1'b1;
        mdl_wb(a, '1, wb_d);
      end
      if (bus.st_ready) begin
        e = st_q.pop_front();
        check_val($sformatf("st_dat%0d", got), bus.st_data, e);
        check_val($sformatf("st_last%0d", got), bus.st_last, (got == NCHUNK - 1));
        got++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        prev_d = bus.st_data;
        prev_l = bus.st_last;
      end
    end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    bus.st_ready = 1'b0;
    check_val("st_count", got, NCHUNK);
    check_val("st_busy_done", bus.busy, 0);
    check_val("st_cmd_rdy", bus.cmd_ready, 1);
  endtask

  initial begin
    logic [VLEN-1:0] v;
    n_tot = 0;
    n_bad = 0;
    mdl_reset();
    bus.rd0_addr = '0; bus.rd1_addr = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_mask = '0; bus.wb_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_store = 1'b0; bus.cmd_reg = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.st_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_cmd_rdy", bus.cmd_ready, 1);
    check_val("rst_ld_rdy", bus.ld_ready, 0);
    check_val("rst_st_vld", bus.st_valid, 0);
    check_val("rst_st_last", bus.st_last, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_vld", bus.reg_valid, 8'hFF);
    check_val("rst_rd0", bus.rd0_data, 0);
    rst_n = 1'b1;

    read_chk(3, "rd_r3");
    check_val("rd_r3_zero", bus.rd0_data, 0);

    do_wb(2, 16'h0001, '1);
    read_chk(2, "wb1_r2");
    v = '0;
    v[31:0] = 32'hFFFF_FFFF;
    check_val("wb1_r2_const", bus.rd0_data, v);
    do_wb(2, 16'h8000, {(VLEN/32){32'h1234_5678}});
    read_chk(2, "wb2_r2");
    check_val("wb2_elem0", bus.rd0_data[31:0], 32'hFFFF_FFFF);
    check_val("wb2_elem15", bus.rd0_data[VLEN-1 -: 32], 32'h1234_5678);

    do_load(5, 32'h0, 1'b0, 1'b0, -1);
    read_chk(5, "ld_r5");
    check_val("ld_r5_e7", bus.rd0_data[7*32 +: 32], 32'h7);
    do_load(5, 32'h0, 1'b1, 1'b0, -1);
    read_chk(5, "ld_gap_r5");

    do_store(5);
    read_chk(5, "st_wb_r5");

    do_load(5, 32'h100, 1'b0, 1'b1, -1);
    read_chk(5, "coll_wb_r5");

    do_load(5, 32'h200, 1'b0, 1'b0, 7);
    read_chk(5, "arst_r5");
    read_chk(2, "arst_r2");
    do_load(1, 32'h300, 1'b1, 1'b0, -1);
    read_chk(1, "post_rst_ld_r1");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
